dma_ctrl: RTL and testbench

//   DMA engine on the CPU's DMA side: requests the shared RAM bus via DMA_Req/DMA_Ack.
//   RX: each byte from the serial RX FIFO is written into a circular RAM buffer.
//   TX: on DMA_Tx_Start it reads TX_LEN bytes from RAM, streams them to the serial

---
 rtl/dma_ctrl.sv | 104 ++++++++++
 tb/tb_dma_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// dma_ctrl: bus-granted DMA moving RX FIFO bytes into a circular RAM buffer
// and streaming a fixed-length RAM block to the serial transmitter on command.
module dma_ctrl #(
    parameter logic [7:0] RX_BASE = 8'h00,
    parameter int         RX_LEN  = 3,
    parameter logic [7:0] TX_BASE = 8'h04,
    parameter int         TX_LEN  = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    output logic       DMA_Req,
    input  logic       DMA_Ack,
    input  logic       DMA_Tx_Start,
    output logic       DMA_Ready,
    input  logic [7:0] RX_Data,
    input  logic       RX_Empty,
    output logic       Data_Read,
    output logic [7:0] TX_Data,
    output logic       TX_Valid,
    input  logic       TX_Ready,
    output logic [7:0] RAM_Addr,
    output logic       RAM_Cs,
    output logic       RAM_Wen,
    output logic       RAM_Oen,
    output logic [7:0] DataOut,
    input  logic [7:0] DataIn
);
    typedef enum logic [3:0] {
        IDLE, RX_REQ, RX_POP, RX_WR, TX_REQ, TX_RD, TX_LATCH, TX_SEND, TX_DONE
    } state_t;

    state_t     state, next;
    logic       start_q, tx_pend, rise, in_tx, granted, abort, tx_abort, last;
    logic [7:0] rx_ptr, tx_idx, rx_byte, tx_reg;

    assign rise     = DMA_Tx_Start & ~start_q;
    assign in_tx    = state inside {TX_REQ, TX_RD, TX_LATCH, TX_SEND, TX_DONE};
    assign granted  = state inside {RX_POP, RX_WR, TX_RD, TX_LATCH, TX_SEND, TX_DONE};
    assign abort    = granted & ~DMA_Ack;
    // A transfer lost mid-flight is re-queued; one already in TX_DONE has completed.
    assign tx_abort = abort & (state inside {TX_RD, TX_LATCH, TX_SEND});
    assign last     = tx_idx == 8'(TX_LEN - 1);

    always_comb begin
        next = state;
        if (abort)
            next = IDLE;
        else
            case (state)
                IDLE:     next = (tx_pend | rise) ? TX_REQ : !RX_Empty ? RX_REQ : IDLE;
                RX_REQ:   next = DMA_Ack ? RX_POP : RX_REQ;
                RX_POP:   next = RX_WR;
                RX_WR:    next = IDLE;
                TX_REQ:   next = DMA_Ack ? TX_RD : TX_REQ;
                TX_RD:    next = TX_LATCH;
                TX_LATCH: next = TX_SEND;
                TX_SEND:  next = TX_Ready ? (last ? TX_DONE : TX_RD) : TX_SEND;
                TX_DONE:  next = IDLE;
                default:  next = IDLE;
            endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            tx_pend <= 1'b0;
            rx_ptr  <= 8'd0;
            tx_idx  <= 8'd0;
            rx_byte <= 8'd0;
            tx_reg  <= 8'd0;
        end else begin
            state   <= next;
            start_q <= DMA_Tx_Start;
            if (tx_abort)
                tx_pend <= 1'b1;
            else if (state == TX_REQ && DMA_Ack)
                tx_pend <= 1'b0;
            else if (rise && !in_tx)
                tx_pend <= 1'b1;
            if (state == RX_POP)
                rx_byte <= RX_Data;
            if (state == RX_WR && DMA_Ack)
                rx_ptr <= (rx_ptr == 8'(RX_LEN - 1)) ? 8'd0 : rx_ptr + 8'd1;
            if (state == TX_REQ && DMA_Ack)
                tx_idx <= 8'd0;
            else if (state == TX_SEND && DMA_Ack && TX_Ready && !last)
                tx_idx <= tx_idx + 8'd1;
            if (state == TX_LATCH)
                tx_reg <= DataIn;
        end
    end

    assign DMA_Req   = state != IDLE;
    assign Data_Read = state == RX_POP;
    assign RAM_Cs    = state == RX_WR || state == TX_RD;
    assign RAM_Wen   = state == RX_WR;
    assign RAM_Oen   = state == TX_RD;
    assign RAM_Addr  = (state == RX_WR) ? RX_BASE + rx_ptr : (state == TX_RD) ? TX_BASE + tx_idx : 8'd0;
    assign DataOut   = (state == RX_WR) ? rx_byte : 8'd0;
    assign TX_Valid  = state == TX_SEND;
    assign TX_Data   = (state == TX_SEND) ? tx_reg : 8'd0;
    assign DMA_Ready = state == TX_DONE;
endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed scenarios against bus-grant, RX FIFO, RAM and transmitter models.
module tb_dma_ctrl;
    logic       Clk = 1'b0, Rst_n = 1'b0, DMA_Ack = 1'b0, DMA_Tx_Start = 1'b0;
    logic       RX_Empty = 1'b1, TX_Ready = 1'b0;
    logic [7:0] RX_Data = 8'h00;
    logic       DMA_Req, DMA_Ready, Data_Read, TX_Valid, RAM_Cs, RAM_Wen, RAM_Oen;
    logic [7:0] TX_Data, RAM_Addr, DataOut, DataIn;

    always #5 Clk = ~Clk;

    dma_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .DMA_Req(DMA_Req), .DMA_Ack(DMA_Ack),
        .DMA_Tx_Start(DMA_Tx_Start), .DMA_Ready(DMA_Ready), .RX_Data(RX_Data),
        .RX_Empty(RX_Empty), .Data_Read(Data_Read), .TX_Data(TX_Data),
        .TX_Valid(TX_Valid), .TX_Ready(TX_Ready), .RAM_Addr(RAM_Addr),
        .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen),
        .DataOut(DataOut), .DataIn(DataIn)
    );

    int checks = 0, errors = 0, cyc = 0;
    int pops = 0, rdys = 0, stab_err = 0;
    int ack_dly = 2, req_cnt = 0, tx_dly = 3, wcnt = 0;
    bit ack_en = 1'b1, pop_pend = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] ram_q = 8'h00, held = 8'h00;
    logic [7:0] rxq[$], wa[$], wd[$], tq[$];
    int         wc[$], tc[$];

    assign DataIn = ram_q;

    always @(posedge Clk) begin
        if (RAM_Cs && RAM_Oen) ram_q <= mem[RAM_Addr];
        if (RAM_Cs && RAM_Wen) mem[RAM_Addr] <= DataOut;
    end

    // Grant follows request after ack_dly cycles; withdrawn whenever ack_en is low.
    always @(negedge Clk) begin
        if (!DMA_Req) begin
            req_cnt = 0;
            DMA_Ack = 1'b0;
        end else if (ack_en && req_cnt >= ack_dly)
            DMA_Ack = 1'b1;
        else begin
            req_cnt++;
            if (!ack_en) DMA_Ack = 1'b0;
        end
    end

    always @(negedge Clk) begin
        cyc++;
        pop_pend = Data_Read;
        if (Data_Read) pops++;
        if (DMA_Ready) rdys++;
        if (RAM_Cs && RAM_Wen) begin
            wa.push_back(RAM_Addr);
            wd.push_back(DataOut);
            wc.push_back(cyc);
        end
    end

    task automatic rx_upd();
        RX_Empty = rxq.size() == 0;
        RX_Data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxq.push_back(b);
        rx_upd();
    endtask

    always @(posedge Clk) begin
        if (pop_pend) begin
            #1;
            if (rxq.size() > 0) rxq.delete(0);
            rx_upd();
        end
    end

    // Transmitter: accepts each byte tx_dly cycles after it appears, checking it stays put.
    always @(negedge Clk) begin
        if (TX_Ready)
            TX_Ready = 1'b0;
        else if (TX_Valid) begin
            if (wcnt > 0 && TX_Data !== held) stab_err++;
            held = TX_Data;
            if (wcnt >= tx_dly) begin
                TX_Ready = 1'b1;
                wcnt = 0;
                tq.push_back(TX_Data);
                tc.push_back(cyc);
            end else
                wcnt++;
        end else
            wcnt = 0;
    end

    function automatic logic [30:0] outs();
        return {DMA_Req, DMA_Ready, Data_Read, TX_Valid, TX_Data, RAM_Addr,
                RAM_Cs, RAM_Wen, RAM_Oen, DataOut};
    endfunction

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic clr();
        wa.delete(); wd.delete(); wc.delete(); tq.delete(); tc.delete();
        pops = 0; rdys = 0; stab_err = 0;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        tick(); tick();
        Rst_n = 1'b1;
        tick();
        clr();
    endtask

    task automatic pulse_start();
        DMA_Tx_Start = 1'b1;
        tick();
        DMA_Tx_Start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (outs() !== 31'd0) begin errors++; $display("FAIL reset_outs got %h want 0", outs()); end
        Rst_n = 1'b1;
        tick();
        checks++; if (outs() !== 31'd0) begin errors++; $display("FAIL idle_outs got %h want 0", outs()); end
    endtask

    task automatic test_rx_single();
        logic [7:0] a, d;
        clr();
        rx_push(8'hA5);
        for (int i = 0; i < 100 && wa.size() == 0; i++) tick();
        a = (wa.size() > 0) ? wa[0] : 8'hxx;
        d = (wd.size() > 0) ? wd[0] : 8'hxx;
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL rx1_addr got %h want 00", a); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rx1_data got %h want a5", d); end
        tick();
        checks++; if (DMA_Req !== 1'b0) begin errors++; $display("FAIL rx1_req_drop got %b want 0", DMA_Req); end
        repeat (5) tick();
        checks++; if (pops !== 1) begin errors++; $display("FAIL rx1_pops got %0d want 1", pops); end
        checks++; if (wa.size() !== 1) begin errors++; $display("FAIL rx1_writes got %0d want 1", wa.size()); end
    endtask

    task automatic test_rx_wrap();
        logic [7:0] ea [5] = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01};
        logic [7:0] ed [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] a, d;
        do_reset();
        rx_push(8'h11); rx_push(8'h22); rx_push(8'h33); rx_push(8'h44); rx_push(8'h55);
        for (int i = 0; i < 500 && wa.size() < 5; i++) tick();
        for (int k = 0; k < 5; k++) begin
            a = (wa.size() > k) ? wa[k] : 8'hxx;
            d = (wd.size() > k) ? wd[k] : 8'hxx;
            checks++; if (a !== ea[k]) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", k, a, ea[k]); end
            checks++; if (d !== ed[k]) begin errors++; $display("FAIL wrap_data%0d got %h want %h", k, d, ed[k]); end
        end
        checks++; if (pops !== 5) begin errors++; $display("FAIL wrap_pops got %0d want 5", pops); end
    endtask

    task automatic test_tx();
        logic [7:0] b0, b1;
        clr();
        tx_dly = 3;
        pulse_start();
        for (int i = 0; i < 300 && rdys == 0; i++) tick();
        b0 = (tq.size() > 0) ? tq[0] : 8'hxx;
        b1 = (tq.size() > 1) ? tq[1] : 8'hxx;
        checks++; if (b0 !== 8'h48) begin errors++; $display("FAIL tx_byte0 got %h want 48", b0); end
        checks++; if (b1 !== 8'h49) begin errors++; $display("FAIL tx_byte1 got %h want 49", b1); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL tx_stable got %0d want 0", stab_err); end
        tick();
        checks++; if (DMA_Req !== 1'b0) begin errors++; $display("FAIL tx_req_drop got %b want 0", DMA_Req); end
        checks++; if (DMA_Ready !== 1'b0) begin errors++; $display("FAIL tx_ready_width got %b want 0", DMA_Ready); end
        repeat (5) tick();
        checks++; if (rdys !== 1) begin errors++; $display("FAIL tx_ready_cnt got %0d want 1", rdys); end
        checks++; if (tq.size() !== 2) begin errors++; $display("FAIL tx_count got %0d want 2", tq.size()); end
    endtask

    task automatic test_priority();
        logic [7:0] b0, b1, a, d;
        int wcy, tcy;
        clr();
        DMA_Tx_Start = 1'b1;
        rx_push(8'h77);
        tick();
        DMA_Tx_Start = 1'b0;
        for (int i = 0; i < 400 && wa.size() == 0; i++) tick();
        b0 = (tq.size() > 0) ? tq[0] : 8'hxx;
        b1 = (tq.size() > 1) ? tq[1] : 8'hxx;
        a = (wa.size() > 0) ? wa[0] : 8'hxx;
        d = (wd.size() > 0) ? wd[0] : 8'hxx;
        wcy = (wc.size() > 0) ? wc[0] : -1;
        tcy = (tc.size() > 1) ? tc[1] : 1 << 30;
        checks++; if (b0 !== 8'h48) begin errors++; $display("FAIL prio_byte0 got %h want 48", b0); end
        checks++; if (b1 !== 8'h49) begin errors++; $display("FAIL prio_byte1 got %h want 49", b1); end
        checks++; if (a !== 8'h02) begin errors++; $display("FAIL prio_addr got %h want 02", a); end
        checks++; if (d !== 8'h77) begin errors++; $display("FAIL prio_data got %h want 77", d); end
        checks++; if (wcy <= tcy) begin errors++; $display("FAIL prio_order write_cyc %0d want after tx_cyc %0d", wcy, tcy); end
        checks++; if (rdys !== 1) begin errors++; $display("FAIL prio_ready got %0d want 1", rdys); end
    endtask

    task automatic test_ack_loss();
        logic [7:0] b0, b1;
        clr();
        tx_dly = 6;
        pulse_start();
        for (int i = 0; i < 100 && !TX_Valid; i++) tick();
        ack_en = 1'b0;
        DMA_Ack = 1'b0;
        tick();
        checks++; if (outs() !== 31'd0) begin errors++; $display("FAIL loss_idle got %h want 0", outs()); end
        tick();
        checks++; if (DMA_Req !== 1'b1) begin errors++; $display("FAIL loss_rereq got %b want 1", DMA_Req); end
        tq.delete();
        tx_dly = 3;
        ack_en = 1'b1;
        for (int i = 0; i < 300 && rdys == 0; i++) tick();
        repeat (10) tick();
        b0 = (tq.size() > 0) ? tq[0] : 8'hxx;
        b1 = (tq.size() > 1) ? tq[1] : 8'hxx;
        checks++; if (b0 !== 8'h48) begin errors++; $display("FAIL loss_byte0 got %h want 48", b0); end
        checks++; if (b1 !== 8'h49) begin errors++; $display("FAIL loss_byte1 got %h want 49", b1); end
        checks++; if (tq.size() !== 2) begin errors++; $display("FAIL loss_count got %0d want 2", tq.size()); end
        checks++; if (rdys !== 1) begin errors++; $display("FAIL loss_ready got %0d want 1", rdys); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a, d;
        clr();
        rx_push(8'h88);
        for (int i = 0; i < 100 && wa.size() == 0; i++) tick();
        tick();
        rx_push(8'h99);
        for (int i = 0; i < 100 && !RAM_Wen; i++) tick();
        checks++; if (RAM_Addr !== 8'h01) begin errors++; $display("FAIL rst_pre_addr got %h want 01", RAM_Addr); end
        Rst_n = 1'b0;
        #1;
        checks++; if (outs() !== 31'd0) begin errors++; $display("FAIL rst_async got %h want 0", outs()); end
        tick();
        Rst_n = 1'b1;
        tick();
        clr();
        rx_push(8'hAB);
        for (int i = 0; i < 100 && wa.size() == 0; i++) tick();
        a = (wa.size() > 0) ? wa[0] : 8'hxx;
        d = (wd.size() > 0) ? wd[0] : 8'hxx;
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL rst_ptr got %h want 00", a); end
        checks++; if (d !== 8'hAB) begin errors++; $display("FAIL rst_data got %h want ab", d); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[4] = 8'h48;
        mem[5] = 8'h49;
        test_reset();
        test_rx_single();
        test_rx_wrap();
        test_tx();
        test_priority();
        test_ack_loss();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
